// File: rtl/axis_fifo_pkg.sv
// Shared types and word layout for the 32-bit AXI-Stream frame FIFO.
// A stored word is {last, keep[3:0], data[31:0]}.
package axis_fifo_pkg;

    localparam int FIFO_WORD_W = 37;

    // Field placement inside one stored word
    localparam int DATA_LSB = 0;
    localparam int DATA_W   = 32;
    localparam int KEEP_LSB = 32;
    localparam int KEEP_W   = 4;
    localparam int LAST_BIT = 36;

    // Write-side frame acceptance states
    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_RECV = 2'd1,
        W_DROP = 2'd2
    } wr_state_e;

    // Build a storage word from the stream fields
    function automatic logic [FIFO_WORD_W-1:0] pack_word(
        input logic              last,
        input logic [KEEP_W-1:0] keep,
        input logic [DATA_W-1:0] data
    );
        logic [FIFO_WORD_W-1:0] w;
        w                       = '0;
        w[DATA_LSB +: DATA_W]   = data;
        w[KEEP_LSB +: KEEP_W]   = keep;
        w[LAST_BIT]             = last;
        return w;
    endfunction

endpackage

// File: rtl/axis_frame_fifo32_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous read
// port, same clock. The array has no reset so it maps onto block RAM.
module sdp_ram #(
    parameter int WIDTH  = 37,
    parameter int ADDR_W = 9
) (
    input  logic              clk_32,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WIDTH-1:0]  rd_data_o
);

    logic [WIDTH-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [WIDTH-1:0] rd_data_q;

    // Write port
    always_ff @(posedge clk_32) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; holds its value when no read is issued
    always_ff @(posedge clk_32) begin
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axis_frame_fifo32.sv
// Store-and-forward frame FIFO between send_top and the 32->8 width
// converter. Frames become visible to the reader only once their last word
// is stored; a frame that does not fit is discarded whole by rewinding the
// write pointer to the last commit point.
module axis_frame_fifo32
    import axis_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_W      = 16
) (
    input  logic             clk_32,
    input  logic             reset_32,
    input  logic [31:0]      s_tdata,
    input  logic [3:0]       s_tkeep,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic [31:0]      m_tdata,
    output logic [3:0]       m_tkeep,
    output logic             m_tvalid,
    output logic             m_tlast,
    input  logic             m_tready,
    output logic [CNT_W-1:0] frames_stored,
    output logic [CNT_W-1:0] frames_dropped,
    output logic             overflow,
    output logic             frames_pending
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] DEPTH_WORDS = {1'b1, {DEPTH_LOG2{1'b0}}};

    // ------------------------------------------------------------------
    // Write side
    // ------------------------------------------------------------------
    wr_state_e              wr_state_q;
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       wr_commit_q;
    logic [CNT_W-1:0]       frames_stored_q;
    logic [CNT_W-1:0]       frames_dropped_q;
    logic                   overflow_q;

    // Read pointer lives on the read side but sets the fill level
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_d;

    logic [PTR_W-1:0]       used;
    logic                   full;
    logic                   accept_word;
    logic [FIFO_WORD_W-1:0] wr_word;

    // Fill level uses the pre-edge read pointer, so a read in the same
    // cycle does not make room for this cycle's write.
    assign used        = wr_ptr_q - rd_ptr_q;
    assign full        = (used == DEPTH_WORDS);
    assign accept_word = s_tvalid && (wr_state_q != W_DROP) && !full;
    assign wr_word     = pack_word(s_tlast, s_tkeep, s_tdata);

    // Frame acceptance FSM: store, commit on last, or rewind and drop
    always_ff @(posedge clk_32 or posedge reset_32) begin
        if (reset_32) begin
            wr_state_q       <= W_IDLE;
            wr_ptr_q         <= '0;
            wr_commit_q      <= '0;
            frames_stored_q  <= '0;
            frames_dropped_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            if (s_tvalid) begin
                case (wr_state_q)
                    W_IDLE, W_RECV: begin
                        if (!full) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            if (s_tlast) begin
                                wr_commit_q     <= wr_ptr_q + 1'b1;
                                frames_stored_q <= frames_stored_q + 1'b1;
                                wr_state_q      <= W_IDLE;
                            end else begin
                                wr_state_q <= W_RECV;
                            end
                        end else begin
                            // No room: forget everything since the last commit
                            wr_ptr_q         <= wr_commit_q;
                            frames_dropped_q <= frames_dropped_q + 1'b1;
                            overflow_q       <= 1'b1;
                            wr_state_q       <= s_tlast ? W_IDLE : W_DROP;
                        end
                    end
                    W_DROP: begin
                        if (s_tlast) begin
                            wr_state_q <= W_IDLE;
                        end
                    end
                    default: begin
                        wr_state_q <= W_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    logic                   rd_issue;
    logic [FIFO_WORD_W-1:0] ram_rd_data;

    sdp_ram #(
        .WIDTH  (FIFO_WORD_W),
        .ADDR_W (DEPTH_LOG2)
    ) u_ram (
        .clk_32    (clk_32),
        .wr_en_i   (accept_word),
        .wr_addr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data_i (wr_word),
        .rd_en_i   (rd_issue),
        .rd_addr_i (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data_o (ram_rd_data)
    );

    // ------------------------------------------------------------------
    // Read side: RAM read stage feeding a 2-entry output skid.
    // A read is issued only if the skid is guaranteed a free slot when
    // the data lands one cycle later, so stalls never lose a word.
    // ------------------------------------------------------------------
    logic                            readable;
    logic                            rd_inflight_q;
    logic                            rd_inflight_d;
    logic [1:0][FIFO_WORD_W-1:0]     skid_q;
    logic [1:0][FIFO_WORD_W-1:0]     skid_d;
    logic [1:0]                      skid_cnt_q;
    logic [1:0]                      skid_cnt_d;
    logic                            pop;
    logic [2:0]                      occ_after;

    assign readable  = (rd_ptr_q != wr_commit_q);
    assign pop       = (skid_cnt_q != 2'd0) && m_tready;
    // Skid occupancy after this edge, before any newly issued read lands
    assign occ_after = {1'b0, skid_cnt_q} + {2'b00, rd_inflight_q} - {2'b00, pop};
    assign rd_issue  = readable && (occ_after <= 3'd1);

    // Next-state for the read pointer, in-flight flag and skid contents
    always_comb begin
        rd_ptr_d      = rd_ptr_q + {{(PTR_W-1){1'b0}}, rd_issue};
        rd_inflight_d = rd_issue;
        skid_d        = skid_q;
        skid_cnt_d    = skid_cnt_q;
        case ({rd_inflight_q, pop})
            2'b01: begin
                // Head leaves, second entry (if any) moves up
                skid_d[0]  = skid_q[1];
                skid_cnt_d = skid_cnt_q - 2'd1;
            end
            2'b10: begin
                // Word arrives from RAM into the first free slot
                if (skid_cnt_q == 2'd0) begin
                    skid_d[0] = ram_rd_data;
                end else begin
                    skid_d[1] = ram_rd_data;
                end
                skid_cnt_d = skid_cnt_q + 2'd1;
            end
            2'b11: begin
                // Head leaves and a word arrives; count unchanged
                if (skid_cnt_q == 2'd1) begin
                    skid_d[0] = ram_rd_data;
                end else begin
                    skid_d[0] = skid_q[1];
                    skid_d[1] = ram_rd_data;
                end
            end
            default: begin
            end
        endcase
    end

    // Read pipeline registers
    always_ff @(posedge clk_32 or posedge reset_32) begin
        if (reset_32) begin
            rd_ptr_q      <= '0;
            rd_inflight_q <= 1'b0;
            skid_q        <= '0;
            skid_cnt_q    <= 2'd0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            rd_inflight_q <= rd_inflight_d;
            skid_q        <= skid_d;
            skid_cnt_q    <= skid_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all taken straight from registers
    // ------------------------------------------------------------------
    assign m_tvalid       = (skid_cnt_q != 2'd0);
    assign m_tdata        = skid_q[0][DATA_LSB +: DATA_W];
    assign m_tkeep        = skid_q[0][KEEP_LSB +: KEEP_W];
    assign m_tlast        = skid_q[0][LAST_BIT];
    assign frames_stored  = frames_stored_q;
    assign frames_dropped = frames_dropped_q;
    assign overflow       = overflow_q;
    // Committed words still in RAM, in the read stage, or in the skid
    assign frames_pending = readable || rd_inflight_q || m_tvalid;

endmodule

// File: tb/tb_axis_frame_fifo32.sv
// Bench for axis_frame_fifo32: two instances (512-word and 16-word buffer),
// frame-level reference model feeding a scoreboard, per-instance monitors.
module tb_axis_frame_fifo32;

    localparam int N_DUT = 2;
    localparam int CNT_W = 16;
    localparam int DL2_0 = 9;
    localparam int DL2_1 = 4;

    logic clk_32 = 1'b0;
    logic reset_32;
    always #5 clk_32 = ~clk_32;

    logic [31:0]      s_tdata        [N_DUT];
    logic [3:0]       s_tkeep        [N_DUT];
    logic             s_tvalid       [N_DUT];
    logic             s_tlast        [N_DUT];
    logic [31:0]      m_tdata        [N_DUT];
    logic [3:0]       m_tkeep        [N_DUT];
    logic             m_tvalid       [N_DUT];
    logic             m_tlast        [N_DUT];
    logic             m_tready       [N_DUT];
    logic [CNT_W-1:0] frames_stored  [N_DUT];
    logic [CNT_W-1:0] frames_dropped [N_DUT];
    logic             overflow       [N_DUT];
    logic             frames_pending [N_DUT];

    int checks = 0;
    int errors = 0;

    // Scoreboard and model state
    logic [36:0] exp_q [N_DUT][$];
    int exp_stored  [N_DUT];
    int exp_dropped [N_DUT];
    int ovf_cnt     [N_DUT];

    // Ready driver control
    int   rdy_mode  = 0;     // 0 constant, 1 pattern 1,0,0,1, 2 random
    logic rdy_const = 1'b1;
    int   rdy_pct   = 60;

    genvar gi;
    for (gi = 0; gi < N_DUT; gi++) begin : g_dut
        localparam int DL2 = (gi == 0) ? DL2_0 : DL2_1;
        axis_frame_fifo32 #(
            .DEPTH_LOG2 (DL2),
            .CNT_W      (CNT_W)
        ) dut (
            .clk_32         (clk_32),
            .reset_32       (reset_32),
            .s_tdata        (s_tdata[gi]),
            .s_tkeep        (s_tkeep[gi]),
            .s_tvalid       (s_tvalid[gi]),
            .s_tlast        (s_tlast[gi]),
            .m_tdata        (m_tdata[gi]),
            .m_tkeep        (m_tkeep[gi]),
            .m_tvalid       (m_tvalid[gi]),
            .m_tlast        (m_tlast[gi]),
            .m_tready       (m_tready[gi]),
            .frames_stored  (frames_stored[gi]),
            .frames_dropped (frames_dropped[gi]),
            .overflow       (overflow[gi]),
            .frames_pending (frames_pending[gi])
        );
    end

    function automatic int depth_of(input int d);
        return (d == 0) ? (1 << DL2_0) : (1 << DL2_1);
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, got, want);
        end
    endtask

    // Monitors: compare every transfer against the scoreboard and verify
    // the output holds steady while stalled.
    for (gi = 0; gi < N_DUT; gi++) begin : g_mon
        bit          held = 1'b0;
        logic [36:0] held_w;
        always @(negedge clk_32) begin : mon
            logic [36:0] got;
            logic [36:0] want;
            if (reset_32) begin
                held = 1'b0;
            end else begin
                got = {m_tlast[gi], m_tkeep[gi], m_tdata[gi]};
                if (overflow[gi]) ovf_cnt[gi]++;
                if (held) begin
                    checks++;
                    if (!m_tvalid[gi] || got != held_w) begin
                        errors++;
                        $display("FAIL stall_hold dut%0d: got valid=%0b word=%h, required valid=1 word=%h",
                                 gi, m_tvalid[gi], got, held_w);
                    end
                end
                if (m_tvalid[gi] && m_tready[gi]) begin
                    checks++;
                    if (exp_q[gi].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_word dut%0d: got %h, required no output", gi, got);
                    end else begin
                        want = exp_q[gi].pop_front();
                        if (got != want) begin
                            errors++;
                            $display("FAIL out_word dut%0d: got %h, required %h", gi, got, want);
                        end
                    end
                end
                held   = m_tvalid[gi] && !m_tready[gi];
                held_w = got;
            end
        end
    end

    // Drive m_tready for both instances just after each rising edge
    initial begin : rdy_drv
        int   phase;
        logic r;
        phase = 0;
        for (int k = 0; k < N_DUT; k++) m_tready[k] = 1'b1;
        forever begin
            @(posedge clk_32);
            #1;
            case (rdy_mode)
                0:       r = rdy_const;
                1:       r = ((phase % 4) == 0) || ((phase % 4) == 3);
                default: r = ($urandom_range(99) < rdy_pct);
            endcase
            phase++;
            for (int k = 0; k < N_DUT; k++) m_tready[k] = r;
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_32);
            #1;
        end
    endtask

    // Send one frame; the model decides up front whether it fits in the
    // words the buffer can still hold (undelivered words occupy space).
    // step == 0 means random data and keep.
    task automatic send_frame(input int d, input int len, input logic [31:0] base,
                              input logic [31:0] step, input logic [3:0] last_keep,
                              input int max_gap, output bit saw_valid);
        bit          kept;
        logic [31:0] dat;
        logic [3:0]  kp;
        logic        lst;
        kept      = (len <= depth_of(d) - exp_q[d].size());
        saw_valid = 1'b0;
        for (int i = 0; i < len; i++) begin
            lst = (i == len - 1);
            if (step == 32'd0) begin
                dat = $urandom;
                kp  = 4'($urandom);
            end else begin
                dat = base + step * 32'(i);
                kp  = lst ? last_keep : 4'hF;
            end
            s_tvalid[d] = 1'b1;
            s_tdata[d]  = dat;
            s_tkeep[d]  = kp;
            s_tlast[d]  = lst;
            if (kept) exp_q[d].push_back({lst, kp, dat});
            tick(1);
            if (m_tvalid[d]) saw_valid = 1'b1;
            s_tvalid[d] = 1'b0;
            s_tlast[d]  = 1'b0;
            if (max_gap > 0) tick($urandom_range(max_gap));
        end
        if (kept) exp_stored[d]++;
        else      exp_dropped[d]++;
        $display("frame dut%0d len=%0d %s", d, len, kept ? "stored" : "dropped");
    endtask

    task automatic wait_drain(input int d, input int budget);
        int n;
        n = 0;
        while ((exp_q[d].size() != 0 || frames_pending[d]) && n < budget) begin
            tick(1);
            n++;
        end
        check("drain_in_time", (n < budget), 1'b1);
    endtask

    // Tlast accepted at edge N; called just after edge N
    task automatic check_latency(input int d, input logic [31:0] first);
        check("lat_valid_edge_n", m_tvalid[d], 1'b0);
        tick(1);
        check("lat_valid_edge_n1", m_tvalid[d], 1'b0);
        tick(1);
        check("lat_valid_edge_n2", m_tvalid[d], 1'b1);
        check("lat_first_data", m_tdata[d], first);
    endtask

    task automatic check_counts(input int d);
        check("frames_stored", frames_stored[d], 64'(CNT_W'(exp_stored[d])));
        check("frames_dropped", frames_dropped[d], 64'(CNT_W'(exp_dropped[d])));
        check("overflow_pulses", ovf_cnt[d], exp_dropped[d]);
    endtask

    task automatic check_reset_vals(input int d);
        check("reset_outputs", {m_tvalid[d], m_tlast[d], overflow[d], frames_pending[d],
                                m_tkeep[d], m_tdata[d]}, 64'd0);
        check("reset_counters", {frames_stored[d], frames_dropped[d]}, 64'd0);
    endtask

    task automatic clear_model();
        for (int k = 0; k < N_DUT; k++) begin
            exp_q[k].delete();
            exp_stored[k]  = 0;
            exp_dropped[k] = 0;
            ovf_cnt[k]     = 0;
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: got no end of test, required completion within budget");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit sv;
        int len, n;
        for (int k = 0; k < N_DUT; k++) begin
            s_tdata[k]  = '0;
            s_tkeep[k]  = '0;
            s_tvalid[k] = 1'b0;
            s_tlast[k]  = 1'b0;
        end
        clear_model();
        reset_32 = 1'b0;
        #2 reset_32 = 1'b1;
        tick(3);
        for (int k = 0; k < N_DUT; k++) check_reset_vals(k);
        reset_32 = 1'b0;
        tick(2);

        // Single 4-word frame, keep 0011 on the last word
        send_frame(0, 4, 32'h1111_1111, 32'h1111_1111, 4'b0011, 0, sv);
        check("single_stored_now", frames_stored[0], 1);
        check_latency(0, 32'h1111_1111);
        wait_drain(0, 50);
        check_counts(0);

        // Store-and-forward: nothing leaves until the whole frame is in
        send_frame(0, 64, 32'h0001_0000, 32'd1, 4'hF, 0, sv);
        check("sf_no_early_valid", sv, 1'b0);
        check_latency(0, 32'h0001_0000);
        wait_drain(0, 200);
        check_counts(0);

        // Backpressure with ready pattern 1,0,0,1 over two back-to-back frames
        rdy_mode = 1;
        send_frame(0, 8, 32'h0002_0000, 32'd1, 4'b0001, 0, sv);
        send_frame(0, 8, 32'h0003_0000, 32'd1, 4'b0111, 0, sv);
        wait_drain(0, 200);
        rdy_mode = 0;
        rdy_const = 1'b1;
        tick(1);
        check_counts(0);

        // Overflow on the 16-word instance: 20-word frame dropped, 3-word kept
        send_frame(1, 20, 32'h000A_0000, 32'd1, 4'hF, 0, sv);
        send_frame(1, 3, 32'h000B_0000, 32'd1, 4'b0011, 0, sv);
        wait_drain(1, 100);
        check("ovf_dropped_is_1", frames_dropped[1], 1);
        check_counts(1);

        // Exactly-full frame kept, following 1-word frame dropped
        rdy_const = 1'b0;
        tick(2);
        send_frame(1, 16, 32'h000C_0000, 32'd1, 4'b0111, 0, sv);
        send_frame(1, 1, 32'h000D_0000, 32'd1, 4'b1111, 0, sv);
        tick(4);
        check("full_pending", frames_pending[1], 1'b1);
        check("full_valid_held", m_tvalid[1], 1'b1);
        check_counts(1);
        rdy_const = 1'b1;
        wait_drain(1, 100);
        check_counts(1);

        // Randomised traffic on both instances, flow-controlled so frames fit
        for (int d = 0; d < N_DUT; d++) begin
            rdy_mode = 2;
            rdy_pct  = (d == 0) ? 60 : 45;
            for (int f = 0; f < 30; f++) begin
                len = $urandom_range(1, (d == 0) ? 48 : 12);
                n = 0;
                while (exp_q[d].size() + len > depth_of(d) && n < 2000) begin
                    tick(1);
                    n++;
                end
                check("flow_wait", (n < 2000), 1'b1);
                send_frame(d, len, 32'd0, 32'd0, 4'd0, 2, sv);
            end
            wait_drain(d, 5000);
            rdy_mode  = 0;
            rdy_const = 1'b1;
            tick(1);
            check_counts(d);
        end

        // Reset in the middle of a frame with a frame waiting at the output
        rdy_const = 1'b0;
        tick(2);
        send_frame(0, 3, 32'h000E_0000, 32'd1, 4'hF, 0, sv);
        tick(4);
        check("pre_reset_valid", m_tvalid[0], 1'b1);
        for (int i = 0; i < 5; i++) begin
            s_tvalid[0] = 1'b1;
            s_tdata[0]  = 32'h5A00 + 32'(i);
            s_tkeep[0]  = 4'hF;
            s_tlast[0]  = 1'b0;
            tick(1);
        end
        s_tvalid[0] = 1'b0;
        #1 reset_32 = 1'b1;
        #1;
        check_reset_vals(0);
        clear_model();
        tick(2);
        reset_32  = 1'b0;
        rdy_const = 1'b1;
        tick(2);
        send_frame(0, 2, 32'h000F_0000, 32'd1, 4'b0011, 0, sv);
        wait_drain(0, 50);
        check("post_reset_stored", frames_stored[0], 1);
        check_counts(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axis_frame_fifo32.md
# axis_frame_fifo32

Store-and-forward frame FIFO on the 32-bit AXI-Stream path between the `send_top` output and the `axis32to8` width converter, all in the `clk_32` domain. `send_top` has no backpressure input, so this block absorbs complete frames and releases a frame downstream only after its last word has been stored. A frame that overflows the buffer is discarded whole, so the MAC side never sees a truncated packet. Drop and frame counters are exported for the debug/LED logic.

## Interface
Parameters:
- `DEPTH_LOG2`, 9: buffer depth is 2^DEPTH_LOG2 32-bit words (512).
- `CNT_W`, 16: width of the status counters.

Ports:
- `clk_32`  in  1  system clock.
- `reset_32`  in  1  reset, asynchronous, active-high.
- `s_tdata`  in  32  input word from `send_top`.
- `s_tkeep`  in  4  byte enables; stored with the word, not interpreted.
- `s_tvalid`  in  1  input word valid. There is no `s_tready`; the word is always consumed.
- `s_tlast`  in  1  last word of the frame.
- `m_tdata`  out  32  output word to `axis32to8`.
- `m_tkeep`  out  4  output byte enables.
- `m_tvalid`  out  1  output valid.
- `m_tlast`  out  1  output last.
- `m_tready`  in  1  downstream ready.
- `frames_stored`  out  CNT_W  count of frames committed since reset; wraps.
- `frames_dropped`  out  CNT_W  count of frames discarded since reset; wraps.
- `overflow`  out  1  one-cycle pulse on the cycle a frame is dropped.
- `frames_pending`  out  1  high while at least one committed frame is not fully read.

## Operation
- Storage words are 37 bits: {last, keep[3:0], data[31:0]}.
- Pointers are DEPTH_LOG2+1 bits: `wr_ptr`, `wr_commit`, `rd_ptr`.
  - used = wr_ptr − rd_ptr, modulo arithmetic.
  - Full when used == 2^DEPTH_LOG2.
  - Readable when rd_ptr != wr_commit.
- Write FSM states are W_IDLE, W_RECV and W_DROP.
- In W_IDLE or W_RECV, on `s_tvalid`:
  - Not full: write the word at wr_ptr and increment wr_ptr.
  - Not full with `s_tlast`: wr_commit <= wr_ptr+1, `frames_stored`++, next state W_IDLE.
  - Not full without `s_tlast`: next state W_RECV.
  - Full: wr_ptr <= wr_commit (rewind), `frames_dropped`++, `overflow`=1.
  - Full with `s_tlast`: next state W_IDLE.
  - Full without `s_tlast`: next state W_DROP.
- In W_DROP, every input word is discarded; `s_tlast` moves the FSM to W_IDLE.
- A frame longer than 2^DEPTH_LOG2 words is always dropped.
- Read side delivers committed words in order, including the stored keep and last bits.
  - A transfer happens on `m_tvalid && m_tready`.
  - `m_*` stay stable while `m_tvalid && !m_tready`.
- A simultaneous read and write in the same cycle are both honoured. The full test uses rd_ptr from before the edge.
- `frames_pending` = (rd_ptr != wr_commit) || (m_tvalid output stage holds a word).

## Timing
- Reset values (asynchronous): all pointers 0, FSM W_IDLE, all counters 0, `m_tvalid`/`m_tlast`/`overflow`/`frames_pending` 0, `m_tdata`/`m_tkeep` 0.
- Reset mid-frame: the partial frame and all buffered frames are lost; outputs return to reset values immediately.
- Latency: the tlast word is accepted at edge N. With an idle output stage, the first word of that frame is on `m_*` with `m_tvalid`=1 after edge N+2 (one cycle RAM read, one cycle output register).
- Throughput: one word per cycle sustained while `m_tready`=1. Back-to-back frames have no bubble.
- Stall: deasserting `m_tready` stalls the output without losing the word in the RAM read stage. A 2-entry skid is required.
- `overflow` is high for exactly the one cycle following the dropping edge. Counters update on the same edge.

## Structure
- Package `axis_fifo_pkg`:
  - Write-state enum.
  - `FIFO_WORD_W`=37.
  - Field offset constants for last/keep/data.
- Sub-module `sdp_ram`:
  - Simple dual-port RAM, parameterised width/depth.
  - Synchronous write and synchronous read, no reset on the array.
- The top level holds the write FSM, pointers, read pipeline/skid and counters.

## Test plan
- Single frame: 4 words 0x11111111..0x44444444, last keep=4'b0011, `m_tready`=1. Output is the same 4 words with `m_tlast` on word 4, keep 0011. First `m_tvalid` 2 cycles after the tlast edge. `frames_stored`=1.
- Store-and-forward: 64-word frame with `m_tready`=1. `m_tvalid` stays 0 until 2 cycles after word 64 is accepted.
- Overflow: DEPTH_LOG2=4. Send a 20-word frame, then a 3-word frame. The first frame is dropped: `overflow` pulses once, `frames_dropped`=1. Only the 3-word frame appears on the output.
- Backpressure: two 8-word frames back-to-back. Toggle `m_tready` with pattern 1,0,0,1 repeating. All 16 words emerge in order, none duplicated or lost, data stable during stalls.
- Full boundary: DEPTH_LOG2=4, `m_tready`=0.
  - A 16-word frame is stored (exactly full) and committed.
  - A following 1-word frame is dropped.
  - With `m_tready`=1, the 16 words are delivered.
- Reset mid-frame: assert `reset_32` after 5 words of a 10-word frame. Outputs go to reset values immediately. A following 2-word frame passes cleanly with `frames_stored`=1.
